// File: rtl/lfsr_rand_range_if.sv
// Control/data bundle for lfsr_rand_range: the requester drives the master side,
// the random source implements the slave side.
interface lfsr_rand_range_if #(
  parameter int unsigned WIDTH = 13
);
  logic             En;
  logic             SeedLoad;
  logic [WIDTH-1:0] SeedValue;
  logic             Req;
  logic [WIDTH-1:0] Base;
  logic [WIDTH-1:0] Limit;
  logic [WIDTH-1:0] RandomValue;
  logic [WIDTH-1:0] Value;
  logic             Valid;
  logic             Busy;
  logic             LockupFlag;

  modport master (
    output En, SeedLoad, SeedValue, Req, Base, Limit,
    input  RandomValue, Value, Valid, Busy, LockupFlag
  );

  modport slave (
    input  En, SeedLoad, SeedValue, Req, Base, Limit,
    output RandomValue, Value, Valid, Busy, LockupFlag
  );
endinterface

// File: rtl/lfsr_rand_range.sv
// Fibonacci LFSR random source with seed loading, zero-lockup recovery and a
// rejection-sampling engine that draws uniformly from [Base, Base+Limit].
module lfsr_rand_range #(
  parameter int unsigned      WIDTH     = 13,
  parameter logic [WIDTH-1:0] TAPS      = 13'h1803,
  parameter logic [WIDTH-1:0] SEED      = 13'h1F2D,
  parameter int unsigned      MAX_TRIES = 8
) (
  input logic              Clk,
  input logic              Rst,
  lfsr_rand_range_if.slave bus
);

  localparam int unsigned     TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0]   LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] lfsr, lfsr_step;
  logic [WIDTH-1:0] base_q, limit_q, mask_q, mask_new;
  logic [WIDTH-1:0] cand, cand_sel, value_q;
  logic [WIDTH:0]   sum;
  logic [TW-1:0]    tries;
  logic             valid_q, lockup_q;
  logic             start, accept, advance;

  assign lfsr_step = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};

  // Smear the highest set bit of Limit downwards to get the 2^k-1 mask.
  always_comb begin
    mask_new = bus.Limit;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      mask_new = mask_new | (mask_new >> i);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    accept     = 1'b0;
    advance    = 1'b0;
    cand       = lfsr & mask_q;
    cand_sel   = cand;
    case (state)
      IDLE: begin
        advance = bus.En;
        if (bus.Req) begin
          start      = 1'b1;
          state_next = DRAW;
        end
      end
      DRAW: begin
        advance = 1'b1;
        if (cand <= limit_q) begin
          accept     = 1'b1;
          state_next = IDLE;
        end else if (tries == LAST_TRY) begin
          // Halving a masked value always lands inside [0, Limit].
          accept     = 1'b1;
          cand_sel   = cand >> 1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sum = {1'b0, base_q} + {1'b0, cand_sel};

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      lfsr     <= SEED;
      value_q  <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      base_q   <= '0;
      limit_q  <= '0;
      mask_q   <= '0;
      tries    <= '0;
    end else begin
      valid_q  <= accept;
      lockup_q <= 1'b0;

      if (bus.SeedLoad) begin
        if (bus.SeedValue != '0) begin
          lfsr <= bus.SeedValue;
        end else begin
          lfsr     <= SEED;
          lockup_q <= 1'b1;
        end
      end else if (lfsr == '0) begin
        lfsr     <= SEED;
        lockup_q <= 1'b1;
      end else if (advance) begin
        lfsr <= lfsr_step;
      end

      if (start) begin
        base_q  <= bus.Base;
        limit_q <= bus.Limit;
        mask_q  <= mask_new;
        tries   <= '0;
      end else if (state == DRAW && !accept) begin
        tries <= tries + 1'b1;
      end

      if (accept) value_q <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

  assign bus.RandomValue = lfsr;
  assign bus.Value       = value_q;
  assign bus.Valid       = valid_q;
  assign bus.Busy        = (state == DRAW);
  assign bus.LockupFlag  = lockup_q;

endmodule

// File: tb/tb_lfsr_rand_range.sv
// Directed bench for lfsr_rand_range: table of ranged draws plus hand-written
// sequences for period, seeding, forced accept, reset abort and back-to-back draws.
`timescale 1ns/1ps
module tb_lfsr_rand_range;

  localparam int unsigned      W    = 13;
  localparam logic [W-1:0]     TAPS = 13'h1803;
  localparam logic [W-1:0]     SEED = 13'h1F2D;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lfsr_rand_range_if #(.WIDTH(W)) b8 ();
  lfsr_rand_range_if #(.WIDTH(W)) b1 ();

  lfsr_rand_range #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED), .MAX_TRIES(8)) dut8 (
    .Clk(clk), .Rst(rst), .bus(b8)
  );
  lfsr_rand_range #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED), .MAX_TRIES(1)) dut1 (
    .Clk(clk), .Rst(rst), .bus(b1)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic         use_seed;
    logic [W-1:0] seed;
    logic [W-1:0] base;
    logic [W-1:0] limit;
    logic [W-1:0] exp_value;
    int           exp_lat;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b8.En = 1'b0; b8.SeedLoad = 1'b0; b8.SeedValue = '0; b8.Req = 1'b0; b8.Base = '0; b8.Limit = '0;
    b1.En = 1'b0; b1.SeedLoad = 1'b0; b1.SeedValue = '0; b1.Req = 1'b0; b1.Base = '0; b1.Limit = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic seed8(input logic [W-1:0] s);
    b8.SeedLoad  = 1'b1;
    b8.SeedValue = s;
    tick();
    b8.SeedLoad  = 1'b0;
    b8.SeedValue = '0;
  endtask

  task automatic draw8(input logic [W-1:0] base, input logic [W-1:0] limit,
                       output logic [W-1:0] val, output int lat, output logic busy_first);
    b8.Base  = base;
    b8.Limit = limit;
    b8.Req   = 1'b1;
    tick();
    busy_first = b8.Busy;
    b8.Req   = 1'b0;
    b8.Base  = 13'h0FFF;
    b8.Limit = 13'h0FFF;
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (b8.Valid) begin
        lat = n;
        break;
      end
    end
    val = b8.Value;
    b8.Base  = '0;
    b8.Limit = '0;
  endtask

  function automatic logic [W-1:0] step(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & TAPS)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v, s;
    int           lat, mism, zeros, period, cnt;
    logic         bf;

    vt[0] = '{1'b0, 13'h0000, 13'd10,   13'd5,    13'd15,   1};
    vt[1] = '{1'b0, 13'h0000, 13'h1FFE, 13'd5,    13'h1FFF, 1};
    vt[2] = '{1'b0, 13'h0000, 13'd100,  13'd0,    13'd100,  1};
    vt[3] = '{1'b0, 13'h0000, 13'd0,    13'd4,    13'd3,    2};
    vt[4] = '{1'b1, 13'h0ABC, 13'd7,    13'd12,   13'd19,   1};
    vt[5] = '{1'b1, 13'h0001, 13'd0,    13'h1FFF, 13'd1,    1};
    vt[6] = '{1'b1, 13'h1000, 13'd3,    13'd2,    13'd3,    1};
    vt[7] = '{1'b1, 13'h0007, 13'd0,    13'd5,    13'd5,    3};

    idle_inputs();
    tick();
    do_reset();

    check("reset_random", b8.RandomValue, SEED);
    check("reset_value",  b8.Value, 0);
    check("reset_valid",  b8.Valid, 0);
    check("reset_busy",   b8.Busy, 0);
    check("reset_lockup", b8.LockupFlag, 0);

    // free-run stepping and period
    b8.En = 1'b1;
    tick();
    check("first_step", b8.RandomValue, 13'h1E5B);
    s = 13'h1E5B; mism = 0; zeros = 0; period = 0;
    for (int i = 2; i <= 8191; i++) begin
      tick();
      s = step(s);
      if (b8.RandomValue !== s) mism++;
      if (b8.RandomValue == '0) zeros++;
      if (period == 0 && b8.RandomValue == SEED) period = i;
    end
    b8.En = 1'b0;
    check("lfsr_track_mismatches", mism, 0);
    check("lfsr_zero_states", zeros, 0);
    check("period_ge_4095", (period >= 4095) ? 1 : 0, 1);
    tick();
    check("hold_when_idle", b8.RandomValue, SEED);

    // seeding and lockup flag
    do_reset();
    b8.En = 1'b1; tick(); tick(); tick(); b8.En = 1'b0;
    seed8('0);
    check("seed_zero_state", b8.RandomValue, SEED);
    check("seed_zero_flag",  b8.LockupFlag, 1);
    tick();
    check("seed_zero_flag_drop", b8.LockupFlag, 0);
    b8.En = 1'b1;
    seed8(13'h0ABC);
    b8.En = 1'b0;
    check("seed_abc_state", b8.RandomValue, 13'h0ABC);
    check("seed_abc_flag",  b8.LockupFlag, 0);

    // table of ranged draws
    foreach (vt[i]) begin
      do_reset();
      if (vt[i].use_seed) begin
        seed8(vt[i].seed);
        check($sformatf("v%0d_seed", i), b8.RandomValue, vt[i].seed);
      end
      draw8(vt[i].base, vt[i].limit, v, lat, bf);
      check($sformatf("v%0d_busy", i),    bf, 1);
      check($sformatf("v%0d_value", i),   v, vt[i].exp_value);
      check($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      check($sformatf("v%0d_busy_end", i), b8.Busy, 0);
      tick();
      check($sformatf("v%0d_valid_pulse", i), b8.Valid, 0);
      check($sformatf("v%0d_value_hold", i),  b8.Value, vt[i].exp_value);
    end

    // forced accept with a single try
    do_reset();
    b1.Base = 13'd0; b1.Limit = 13'd4; b1.Req = 1'b1;
    tick();
    b1.Req = 1'b0;
    check("forced_busy", b1.Busy, 1);
    tick();
    check("forced_valid", b1.Valid, 1);
    check("forced_value", b1.Value, 2);
    check("forced_busy_end", b1.Busy, 0);

    // reset in the middle of a draw
    do_reset();
    seed8(13'h0007);
    b8.Base = 13'd0; b8.Limit = 13'd5; b8.Req = 1'b1;
    tick();
    b8.Req = 1'b0;
    tick();
    check("abort_busy_before", b8.Busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_busy",   b8.Busy, 0);
    check("abort_valid",  b8.Valid, 0);
    check("abort_random", b8.RandomValue, SEED);
    check("abort_value",  b8.Value, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b8.Valid) cnt++;
    end
    check("abort_no_valid", cnt, 0);

    // Req held while busy is not queued
    do_reset();
    seed8(13'h0007);
    b8.Base = 13'd0; b8.Limit = 13'd5; b8.Req = 1'b1;
    tick(); tick(); tick();
    b8.Req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (b8.Valid) cnt++;
    end
    check("busy_req_pulses", cnt, 1);
    check("busy_req_value",  b8.Value, 5);

    // back-to-back draws: Req coincident with Valid
    do_reset();
    b8.Base = 13'd10; b8.Limit = 13'd5; b8.Req = 1'b1;
    tick();
    b8.Req = 1'b0;
    tick();
    check("b2b_first_valid", b8.Valid, 1);
    check("b2b_first_value", b8.Value, 15);
    b8.Base = 13'd0; b8.Limit = 13'd4; b8.Req = 1'b1;
    tick();
    b8.Req = 1'b0;
    check("b2b_second_busy",  b8.Busy, 1);
    check("b2b_second_valid_low", b8.Valid, 0);
    tick();
    check("b2b_second_valid", b8.Valid, 1);
    check("b2b_second_value", b8.Value, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
